// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the Register_File write port between two writeback
// requesters. It stages the granted write one cycle and forwards it onto both read ports.
module regfile_write_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid_i,
  input  logic [4:0]   req0_addr_i,
  input  logic [N-1:0] req0_data_i,
  output logic         req0_ready_o,
  input  logic         req1_valid_i,
  input  logic [4:0]   req1_addr_i,
  input  logic [N-1:0] req1_data_i,
  output logic         req1_ready_o,
  output logic         Reg_Write_o,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o,
  input  logic [4:0]   Read_Register_1_i,
  input  logic [4:0]   Read_Register_2_i,
  input  logic [N-1:0] Read_Data_1_i,
  input  logic [N-1:0] Read_Data_2_i,
  output logic [N-1:0] Read_Data_1_o,
  output logic [N-1:0] Read_Data_2_o
);

  logic         grant0;
  logic         grant1;
  logic         reg_write_q, reg_write_d;
  logic [4:0]   wr_addr_q, wr_addr_d;
  logic [N-1:0] wr_data_q, wr_data_d;
  logic         prio_q, prio_d;

  // Ready is suppressed while reset is held so no write is accepted into a clearing stage.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0_valid_i && req1_valid_i) begin
        grant0 = ~prio_q;
        grant1 = prio_q;
      end else begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i;
      end
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Writes to x0 are consumed, and they still rotate priority, but they never assert the enable.
  always_comb begin
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    prio_d      = prio_q;
    if (grant0) begin
      wr_addr_d   = req0_addr_i;
      wr_data_d   = req0_data_i;
      reg_write_d = (req0_addr_i != 5'd0);
      prio_d      = 1'b1;
    end else if (grant1) begin
      wr_addr_d   = req1_addr_i;
      wr_data_d   = req1_data_i;
      reg_write_d = (req1_addr_i != 5'd0);
      prio_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= '0;
      prio_q      <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      prio_q      <= prio_d;
    end
  end

  assign Reg_Write_o      = reg_write_q;
  assign Write_Register_o = wr_addr_q;
  assign Write_Data_o     = wr_data_q;

  // The staged write lands in Register_File at the next edge, so readers in this cycle take it from here.
  always_comb begin
    Read_Data_1_o = Read_Data_1_i;
    Read_Data_2_o = Read_Data_2_i;
    if (reg_write_q && (wr_addr_q == Read_Register_1_i) && (Read_Register_1_i != 5'd0))
      Read_Data_1_o = wr_data_q;
    if (reg_write_q && (wr_addr_q == Read_Register_2_i) && (Read_Register_2_i != 5'd0))
      Read_Data_2_o = wr_data_q;
  end

  one_grant_a : assert property (@(posedge clk) disable iff (reset)
    !(req0_ready_o && req1_ready_o));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter, with a behavioural arbiter model and an attached register file.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        r0, r1;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  rr1 = '0, rr2 = '0;
  logic [31:0] rd1_raw, rd2_raw, rd1_o, rd2_o;

  logic [31:0] rf [32];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.N(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(v0), .req0_addr_i(a0), .req0_data_i(d0), .req0_ready_o(r0),
    .req1_valid_i(v1), .req1_addr_i(a1), .req1_data_i(d1), .req1_ready_o(r1),
    .Reg_Write_o(we), .Write_Register_o(wa), .Write_Data_o(wd),
    .Read_Register_1_i(rr1), .Read_Register_2_i(rr2),
    .Read_Data_1_i(rd1_raw), .Read_Data_2_i(rd2_raw),
    .Read_Data_1_o(rd1_o), .Read_Data_2_o(rd2_o)
  );

  // Register_File that the DUT drives. x0 is hardwired to zero.
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (we && wa != 5'd0) rf[wa] <= wd;
  assign rd1_raw = rf[rr1];
  assign rd2_raw = rf[rr2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who wins, what gets staged, and which requester is favoured next.
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_prio = 1'b0;
  int          m_win;

  function automatic int winner(input logic p, input logic x0, input logic x1);
    if (x0 && x1) return p ? 1 : 0;
    if (x0) return 0;
    if (x1) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_we = 1'b0; m_addr = '0; m_data = '0; m_prio = 1'b0;
    end else begin
      m_win = winner(m_prio, v0, v1);
      if (m_win < 0) m_we = 1'b0;
      else begin
        m_addr = (m_win == 1) ? a1 : a0;
        m_data = (m_win == 1) ? d1 : d0;
        m_we   = (m_addr != 5'd0);
        m_prio = (m_win == 0);
      end
    end
  end

  always @(negedge clk) begin
    int w;
    w = reset ? -1 : winner(m_prio, v0, v1);
    chk("ready0", r0, (w == 0));
    chk("ready1", r1, (w == 1));
    chk("reg_write", we, m_we);
    chk("write_reg", wa, m_addr);
    chk("write_data", wd, m_data);
    chk("read1_bypass", rd1_o, (m_we && m_addr == rr1 && rr1 != 0) ? m_data : rd1_raw);
    chk("read2_bypass", rd2_o, (m_we && m_addr == rr2 && rr2 != 0) ? m_data : rd2_raw);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  exp_a [4];
    logic [31:0] exp_d [4];
    logic        exp_r0 [4];
    exp_a  = '{5'd1, 5'd2, 5'd1, 5'd2};
    exp_d  = '{32'h100, 32'h200, 32'h101, 32'h201};
    exp_r0 = '{1'b1, 1'b0, 1'b1, 1'b0};

    // reset state, ready held low under reset even with a valid present
    step(); step();
    chk("rst_we", we, 1'b0);
    chk("rst_wa", wa, 5'd0);
    chk("rst_wd", wd, 32'h0);
    v0 = 1'b1; a0 = 5'd3;
    #1 chk("rst_ready0", r0, 1'b0);
    v0 = 1'b0;
    step();
    reset = 1'b0;

    // single requester
    v0 = 1'b1; a0 = 5'd7; d0 = 32'hDEADBEEF;
    #1 chk("single_ready0", r0, 1'b1);
    chk("single_ready1", r1, 1'b0);
    step(); v0 = 1'b0;
    chk("single_we", we, 1'b1);
    chk("single_wa", wa, 5'd7);
    chk("single_wd", wd, 32'hDEADBEEF);
    step();
    chk("single_rf7", rf[7], 32'hDEADBEEF);
    chk("single_we_drop", we, 1'b0);

    // x0 write from req1 (prio is 1 here, flips back to 0)
    v1 = 1'b1; a1 = 5'd0; d1 = 32'hFFFFFFFF; rr1 = 5'd0; rr2 = 5'd0;
    #1 chk("x0_ready1", r1, 1'b1);
    step(); v1 = 1'b0;
    #1 chk("x0_we", we, 1'b0);
    chk("x0_wd_loaded", wd, 32'hFFFFFFFF);
    chk("x0_rd1", rd1_o, 32'h0);
    chk("x0_rd2", rd2_o, 32'h0);

    // contention: alternate 0,1,0,1
    v0 = 1'b1; a0 = 5'd1; d0 = 32'h100;
    v1 = 1'b1; a1 = 5'd2; d1 = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1 chk("cont_ready0", r0, exp_r0[i]);
      chk("cont_ready1", r1, !exp_r0[i]);
      step();
      chk("cont_wa", wa, exp_a[i]);
      chk("cont_wd", wd, exp_d[i]);
      if (exp_r0[i]) d0 = d0 + 1; else d1 = d1 + 1;
    end
    v0 = 1'b0; v1 = 1'b0;

    // same target, serialized in grant order
    v0 = 1'b1; a0 = 5'd9; d0 = 32'h11;
    v1 = 1'b1; a1 = 5'd9; d1 = 32'h22;
    #1 chk("same_ready0", r0, 1'b1);
    chk("same_ready1", r1, 1'b0);
    step(); v0 = 1'b0;
    chk("same_wd0", wd, 32'h11);
    #1 chk("same_ready1b", r1, 1'b1);
    step(); v1 = 1'b0;
    chk("same_wd1", wd, 32'h22);
    chk("same_rf9_first", rf[9], 32'h11);
    step();
    chk("same_rf9_final", rf[9], 32'h22);

    // bypass on both ports, then passthrough
    v0 = 1'b1; a0 = 5'd12; d0 = 32'hCAFE0001;
    step(); v0 = 1'b0; rr1 = 5'd12; rr2 = 5'd12;
    #1 chk("byp_raw", rd1_raw, 32'h0);
    chk("byp_rd1", rd1_o, 32'hCAFE0001);
    chk("byp_rd2", rd2_o, 32'hCAFE0001);
    step();
    chk("pass_rd1", rd1_o, 32'hCAFE0001);
    rr1 = 5'd13;
    #1 chk("pass_rd1_x13", rd1_o, 32'h0);
    v1 = 1'b1; a1 = 5'd3; d1 = 32'h33;
    step(); v1 = 1'b0; rr1 = 5'd12; rr2 = 5'd3;
    #1 chk("byp_port2_only", rd2_o, 32'h33);
    chk("byp_port1_raw", rd1_o, 32'hCAFE0001);

    // async reset with a staged write to x5
    v0 = 1'b1; a0 = 5'd5; d0 = 32'h55;
    step(); v0 = 1'b0;
    chk("prerst_we", we, 1'b1);
    #1 reset = 1'b1;
    #1 chk("midrst_we", we, 1'b0);
    chk("midrst_wa", wa, 5'd0);
    chk("midrst_wd", wd, 32'h0);
    v0 = 1'b1; a0 = 5'd6; d0 = 32'h66;
    v1 = 1'b1; a1 = 5'd7; d1 = 32'h77;
    #1 chk("midrst_ready0", r0, 1'b0);
    chk("midrst_ready1", r1, 1'b0);
    step();
    chk("midrst_rf5", rf[5], 32'h0);
    reset = 1'b0;
    #1 chk("postrst_ready0", r0, 1'b1);
    chk("postrst_ready1", r1, 1'b0);
    step(); v0 = 1'b0;
    chk("postrst_wa", wa, 5'd6);
    #1 chk("postrst_ready1b", r1, 1'b1);
    step(); v1 = 1'b0;
    chk("postrst_wa2", wa, 5'd7);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32 x 32-bit `Register_File` between two writeback requesters, such as the ALU result path and a multi-cycle load unit. It applies round-robin arbitration with valid/ready handshakes and stages the granted write in an output register. It also forwards the staged write onto both read ports, so a reader in the cycle the write is pending sees the new value. It sits between the writeback sources and `Register_File`.

## Interface
- `N`, 32, data width of write data and read data.
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req0_valid_i`  in  1  requester 0 has a write.
- `req0_addr_i`  in  5  destination register of requester 0.
- `req0_data_i`  in  N  write data of requester 0.
- `req0_ready_o`  out  1  requester 0 write accepted this cycle.
- `req1_valid_i`, `req1_addr_i`, `req1_data_i`, `req1_ready_o`  same for requester 1.
- `Reg_Write_o`  out  1  write enable to `Register_File`.
- `Write_Register_o`  out  5  write address to `Register_File`.
- `Write_Data_o`  out  N  write data to `Register_File`.
- `Read_Register_1_i`, `Read_Register_2_i`  in  5  read addresses, identical to those driven to `Register_File`.
- `Read_Data_1_i`, `Read_Data_2_i`  in  N  raw read data from `Register_File`.
- `Read_Data_1_o`, `Read_Data_2_o`  out  N  read data after bypass.

## Operation
- **State:**
  - staged write register {`Reg_Write_o`, `Write_Register_o`, `Write_Data_o`}.
  - 1-bit priority pointer `prio`, where 0 means requester 0 wins a tie.
- **Arbitration (combinational, every cycle):**
  - Neither valid: no grant.
  - Exactly one valid: that requester is granted.
  - Both valid: requester `prio` is granted.
  - `reqX_ready_o` = grant to X. At most one ready is high per cycle.
  - Ready depends on valid. Requesters must not make valid depend on ready.
  - Once asserted, valid, addr and data hold until accepted.
- **Accept edge (valid & ready):**
  - Staged register loads addr and data.
  - `Reg_Write_o` loads 1, except when addr = 0: then it loads 0, the write is consumed and dropped, and address and data still load.
  - `prio` loads the index of the non-granted requester, for any grant including x0 writes.
- **No accept edge:**
  - `Reg_Write_o` loads 0.
  - `Write_Register_o` and `Write_Data_o` hold.
  - `prio` holds.
- The staged register never stalls. `Register_File` consumes a write every cycle, so one write per cycle is sustained.
- **Bypass, per port p:**
  - `Read_Data_p_o` = `Write_Data_o` if `Reg_Write_o` = 1, `Write_Register_o` = `Read_Register_p_i` and `Read_Register_p_i` ≠ 0.
  - Otherwise `Read_Data_p_o` = `Read_Data_p_i`.
  - Reads of x0 always pass through, returning 0.
- **Same-register conflict:** if both requesters target the same register in the same cycle, the writes are serialized in grant order. The last accepted value is the final register content.

## Timing
- **Reset values:**
  - `Reg_Write_o` = 0, `Write_Register_o` = 0, `Write_Data_o` = 0.
  - `prio` = 0.
  - `req0_ready_o` and `req1_ready_o` are 0 while `reset` is high.
- **Reset mid-operation:** a staged write is discarded asynchronously and never reaches `Register_File`. Requesters keep their valids and are re-arbitrated from `prio` = 0 after reset deasserts.
- **Latency:**
  - Accept at edge k; `Reg_Write_o` is high during cycle k to k+1.
  - `Register_File` updates at edge k+1.
  - The bypass covers reads during cycle k to k+1. Reads after edge k+1 come from `Register_File` directly.
- **Fairness:** with both requesters continuously valid, grants alternate 0,1,0,1,… starting from the current `prio`. Worst-case wait for a valid requester is 1 cycle.
- **Outputs:**
  - Ready and bypass outputs are combinational from inputs and state.
  - Write-port outputs are registered only.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle with a staged write (`Reg_Write_o` = 1, addr 5) → `Reg_Write_o` drops to 0 immediately; all outputs 0; x5 unchanged.
- **Single requester:** req0 writes x7 = 0xDEADBEEF, req1 idle → `req0_ready_o` = 1 same cycle; next cycle `Reg_Write_o` = 1, addr 7; x7 reads 0xDEADBEEF after the following edge.
- **Contention:** both valid continuously for 4 cycles, req0 to x1, req1 to x2 with incrementing data → grant order 0,1,0,1; `Write_Register_o` sequence 1,2,1,2; each ready high exactly on its grant cycle.
- **Same target:** req0 and req1 both write x9 in the same cycle, req0 = 0x11, req1 = 0x22, `prio` = 0 → x9 = 0x11 then 0x22; final x9 = 0x22.
- **x0:** req1 writes x0 = 0xFFFFFFFF → `req1_ready_o` = 1, `Reg_Write_o` stays 0, `prio` flips; reading x0 on both ports returns 0, with no bypass.
- **Bypass:** stage a write of x12 = 0xCAFE0001 and drive `Read_Register_1_i` = `Read_Register_2_i` = 12 with raw data 0 in the same cycle → `Read_Data_1_o` = `Read_Data_2_o` = 0xCAFE0001. One cycle later, with no new write, both outputs pass the raw input through.
